// File: rtl/commit_mon_pkg.sv
// commit_monitor shared types
// state enum, trace record layout, flag bit positions
package commit_mon_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    DONE
  } state_t;

  typedef struct packed {
    logic        halt;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_value;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  localparam int HALT_BIT      = 54;
  localparam int REG_WRITE_BIT = 53;
  localparam int MEM_READ_BIT  = 52;
  localparam int MEM_WRITE_BIT = 51;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: shift-register FIFO
// entry 0 is the registered head; pop shifts down
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 55
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    wi;
  logic             pop;
  logic             accept;

  assign pop    = valid & ready;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = push & (~full | pop);
  assign wi     = pop ? count - 1'b1 : count;
  assign dout   = regs[0];

  // occupancy update for push, pop or both
  always_comb begin
    count_next = count;
    unique case ({accept, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // storage shift, write slot and registered valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      count <= count_next;
      valid <= (count_next != '0);
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (accept && wi == CW'(i)) begin
          regs[i] <= din;
        end else if (pop) begin
          regs[i] <= regs[i+1];
        end
      end
      if (accept && wi == CW'(DEPTH - 1)) begin
        regs[DEPTH-1] <= din;
      end
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: retire observer
// perf counters, trace FIFO, halt/drain FSM
module commit_monitor
  import commit_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  input  logic [15:0]      inst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [54:0]      trace_data,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] icache_req_count,
  output logic [CNT_W-1:0] icache_hit_count,
  output logic [CNT_W-1:0] dcache_req_count,
  output logic [CNT_W-1:0] dcache_hit_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             halted,
  output logic             done
);

  state_t     state;
  state_t     state_next;
  trace_rec_t rec;
  logic       run;
  logic       commit;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;
  logic       unused_pc_inst;

  assign unused_pc_inst = ^{pc, inst};

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  assign run    = (state == RUN);
  assign commit = run & (halt | reg_write | mem_read | mem_write);
  assign pop    = trace_valid & trace_ready;
  assign drop   = commit & full & ~pop;

  // pack the committing instruction into a trace record
  always_comb begin
    rec            = '0;
    rec.halt       = halt;
    rec.reg_write  = reg_write;
    rec.mem_read   = mem_read;
    rec.mem_write  = mem_write;
    rec.write_reg  = write_reg;
    rec.write_data = write_data;
    rec.mem_addr   = mem_addr;
    rec.mem_value  = mem_write ? mem_data_in : mem_data_out;
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .din   (rec),
    .ready (trace_ready),
    .valid (trace_valid),
    .dout  (trace_data),
    .full  (full),
    .empty (empty)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // halt freezes; drained buffer completes
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (halt)  state_next = HALTED;
      HALTED:  if (empty) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    halted = 1'b0;
    done   = 1'b0;
    unique case (state)
      HALTED:  halted = 1'b1;
      DONE: begin
        halted = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  // saturating performance counters, live only in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count      <= '0;
      inst_count       <= '0;
      icache_req_count <= '0;
      icache_hit_count <= '0;
      dcache_req_count <= '0;
      dcache_hit_count <= '0;
      drop_count       <= '0;
      overflow         <= 1'b0;
    end else if (run) begin
      cycle_count      <= sat_inc(cycle_count, 1'b1);
      inst_count       <= sat_inc(inst_count,
                                  halt | reg_write | mem_write);
      icache_req_count <= sat_inc(icache_req_count, icache_req);
      icache_hit_count <= sat_inc(icache_hit_count, icache_hit);
      dcache_req_count <= sat_inc(dcache_req_count, dcache_req);
      dcache_hit_count <= sat_inc(dcache_hit_count, dcache_hit);
      drop_count       <= sat_inc(drop_count, drop);
      overflow         <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed bench
// hand-computed records and counter values
module tb_commit_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc = '0, inst = '0;
  logic        reg_write = 0, mem_read = 0, mem_write = 0, halt = 0;
  logic [2:0]  write_reg = '0;
  logic [15:0] write_data = '0, mem_addr = '0;
  logic [15:0] mem_data_in = '0, mem_data_out = '0;
  logic        icache_req = 0, icache_hit = 0;
  logic        dcache_req = 0, dcache_hit = 0;
  logic        trace_ready = 0;
  logic        trace_valid, overflow, halted, done;
  logic [54:0] trace_data;
  logic [31:0] cycle_count, inst_count, drop_count;
  logic [31:0] icache_req_count, icache_hit_count;
  logic [31:0] dcache_req_count, dcache_hit_count;

  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;
  bit frozen = 0;

  always #5 clk = ~clk;

  commit_monitor #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .halt(halt), .icache_req(icache_req),
    .icache_hit(icache_hit), .dcache_req(dcache_req),
    .dcache_hit(dcache_hit), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .icache_req_count(icache_req_count),
    .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count),
    .dcache_hit_count(dcache_hit_count),
    .drop_count(drop_count), .overflow(overflow),
    .halted(halted), .done(done)
  );

  function automatic logic [54:0] mk(
    input logic h, input logic rw, input logic mr, input logic mw,
    input logic [2:0] r, input logic [15:0] wd,
    input logic [15:0] ma, input logic [15:0] mv);
    return {h, rw, mr, mw, r, wd, ma, mv};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!frozen) exp_cyc++;
    #1;
  endtask

  task automatic clear_in();
    reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
    write_reg = '0; write_data = '0; mem_addr = '0;
    mem_data_in = '0; mem_data_out = '0;
    icache_req = 0; icache_hit = 0;
    dcache_req = 0; dcache_hit = 0;
    pc = pc + 16'd2; inst = inst ^ 16'h5A5A;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    checks++;
    if ({trace_valid, overflow, halted, done} !== 4'b0 ||
        trace_data !== 55'd0 || cycle_count !== 0 ||
        inst_count !== 0 || drop_count !== 0 ||
        icache_req_count !== 0 || icache_hit_count !== 0 ||
        dcache_req_count !== 0 || dcache_hit_count !== 0) begin
      errors++;
      $display("FAIL %s: v=%b ov=%b h=%b d=%b td=%h cyc=%0d inst=%0d drop=%0d want all 0",
               tag, trace_valid, overflow, halted, done,
               trace_data, cycle_count, inst_count, drop_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_cyc = 0;
    frozen = 0;
  endtask

  task automatic test_reset();
    clear_in();
    do_reset("reset_values");
    repeat (10) tick();
    checks++;
    if (cycle_count !== 32'd10 || inst_count !== 0 ||
        icache_req_count !== 0 || dcache_req_count !== 0 ||
        trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle10: cyc=%0d inst=%0d v=%b want 10 0 0",
               cycle_count, inst_count, trace_valid);
    end
  endtask

  task automatic test_alu_store();
    trace_ready = 1;
    clear_in();
    reg_write = 1; write_reg = 3'd3; write_data = 16'h1234;
    tick();
    clear_in();
    mem_write = 1; mem_addr = 16'h0040; mem_data_in = 16'hBEEF;
    mem_data_out = 16'h1111;
    checks++;
    if (trace_valid !== 1'b1 ||
        trace_data !== mk(0,1,0,0,3'd3,16'h1234,16'h0,16'h0)) begin
      errors++;
      $display("FAIL add_rec: v=%b got %h want %h", trace_valid,
               trace_data, mk(0,1,0,0,3'd3,16'h1234,16'h0,16'h0));
    end
    tick();
    clear_in();
    checks++;
    if (trace_valid !== 1'b1 ||
        trace_data !== mk(0,0,0,1,3'd0,16'h0,16'h0040,16'hBEEF)) begin
      errors++;
      $display("FAIL store_rec: v=%b got %h want %h", trace_valid,
               trace_data, mk(0,0,0,1,3'd0,16'h0,16'h0040,16'hBEEF));
    end
    tick();
    checks++;
    if (trace_valid !== 1'b0 || inst_count !== 32'd2 ||
        cycle_count !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL alu_store_cnt: v=%b inst=%0d cyc=%0d want 0 2 %0d",
               trace_valid, inst_count, cycle_count, exp_cyc);
    end
  endtask

  task automatic test_load();
    trace_ready = 1;
    clear_in();
    mem_read = 1; reg_write = 1; write_reg = 3'd2;
    write_data = 16'h5A5A; mem_addr = 16'h0080;
    mem_data_out = 16'h5A5A; mem_data_in = 16'h9999;
    tick();
    clear_in();
    checks++;
    if (trace_valid !== 1'b1 ||
        trace_data !== mk(0,1,1,0,3'd2,16'h5A5A,16'h0080,16'h5A5A)) begin
      errors++;
      $display("FAIL load_rec: v=%b got %h", trace_valid, trace_data);
    end
    tick();
    checks++;
    if (trace_valid !== 1'b0 || inst_count !== 32'd3) begin
      errors++;
      $display("FAIL load_cnt: v=%b inst=%0d want 0 3",
               trace_valid, inst_count);
    end
  endtask

  task automatic test_overflow_push_pop();
    logic [2:0]  r;
    logic [15:0] d;
    trace_ready = 0;
    for (int i = 0; i < 10; i++) begin
      clear_in();
      reg_write = 1; write_reg = 3'(i);
      write_data = 16'h0100 + 16'(i);
      tick();
    end
    clear_in();
    checks++;
    if (drop_count !== 32'd2 || overflow !== 1'b1 ||
        trace_valid !== 1'b1 ||
        trace_data !== mk(0,1,0,0,3'd0,16'h0100,16'h0,16'h0)) begin
      errors++;
      $display("FAIL overflow: drop=%0d ov=%b v=%b td=%h want 2 1 1",
               drop_count, overflow, trace_valid, trace_data);
    end
    reg_write = 1; write_reg = 3'd7; write_data = 16'h02AA;
    trace_ready = 1;
    tick();
    clear_in();
    trace_ready = 0;
    checks++;
    if (drop_count !== 32'd2 ||
        trace_data !== mk(0,1,0,0,3'd1,16'h0101,16'h0,16'h0)) begin
      errors++;
      $display("FAIL full_push_pop: drop=%0d td=%h want 2",
               drop_count, trace_data);
    end
    trace_ready = 1;
    for (int k = 0; k < 8; k++) begin
      if (k < 7) begin
        r = 3'(k + 1);
        d = 16'h0101 + 16'(k);
      end else begin
        r = 3'd7;
        d = 16'h02AA;
      end
      checks++;
      if (trace_valid !== 1'b1 ||
          trace_data !== mk(0,1,0,0,r,d,16'h0,16'h0)) begin
        errors++;
        $display("FAIL drain[%0d]: v=%b got %h want %h", k,
                 trace_valid, trace_data, mk(0,1,0,0,r,d,16'h0,16'h0));
      end
      tick();
    end
    checks++;
    if (trace_valid !== 1'b0 || inst_count !== 32'd14) begin
      errors++;
      $display("FAIL drain_end: v=%b inst=%0d want 0 14",
               trace_valid, inst_count);
    end
  endtask

  task automatic test_halt();
    logic [54:0] exp [4];
    int wait_n;
    trace_ready = 0;
    for (int k = 0; k < 3; k++) begin
      clear_in();
      reg_write = 1; write_reg = 3'(k + 4);
      write_data = 16'hA000 + 16'(k);
      icache_req = (k < 2); icache_hit = (k < 2);
      dcache_req = (k == 2);
      exp[k] = mk(0,1,0,0,3'(k + 4),16'hA000 + 16'(k),16'h0,16'h0);
      tick();
    end
    exp[3] = mk(1,0,0,0,3'd0,16'h0,16'h0,16'h0);
    clear_in();
    halt = 1; dcache_req = 1; dcache_hit = 1;
    tick();
    frozen = 1;
    clear_in();
    checks++;
    if (halted !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL halted_rise: halted=%b done=%b want 1 0",
               halted, done);
    end
    for (int k = 0; k < 5; k++) begin
      halt = k[0]; reg_write = 1; mem_write = 1; mem_read = 1;
      icache_req = 1; icache_hit = 1;
      dcache_req = 1; dcache_hit = 1;
      tick();
    end
    clear_in();
    checks++;
    if (inst_count !== 32'd18 || icache_req_count !== 32'd2 ||
        icache_hit_count !== 32'd2 || dcache_req_count !== 32'd2 ||
        dcache_hit_count !== 32'd1 || drop_count !== 32'd2 ||
        cycle_count !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL frozen: inst=%0d ic=%0d/%0d dc=%0d/%0d drop=%0d cyc=%0d want 18 2/2 2/1 2 %0d",
               inst_count, icache_req_count, icache_hit_count,
               dcache_req_count, dcache_hit_count, drop_count,
               cycle_count, exp_cyc);
    end
    trace_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== exp[k] ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL halt_drain[%0d]: v=%b done=%b got %h want %h",
                 k, trace_valid, done, trace_data, exp[k]);
      end
      tick();
    end
    wait_n = 0;
    while (done !== 1'b1 && wait_n < 4) begin
      tick();
      wait_n++;
    end
    checks++;
    if (done !== 1'b1 || halted !== 1'b1 || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_rise: done=%b halted=%b v=%b want 1 1 0",
               done, halted, trace_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    trace_ready = 0;
    do_reset("reset_after_done");
    for (int k = 0; k < 4; k++) begin
      clear_in();
      if (k < 3) begin
        reg_write = 1; write_data = 16'hC000 + 16'(k);
      end else begin
        halt = 1;
      end
      tick();
    end
    frozen = 1;
    clear_in();
    trace_ready = 1;
    tick();
    tick();
    trace_ready = 0;
    do_reset("reset_mid_drain");
    clear_in();
    reg_write = 1; write_reg = 3'd1; write_data = 16'h7777;
    tick();
    clear_in();
    checks++;
    if (trace_valid !== 1'b1 || halted !== 1'b0 ||
        trace_data !== mk(0,1,0,0,3'd1,16'h7777,16'h0,16'h0) ||
        cycle_count !== 32'(exp_cyc) || inst_count !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_run: v=%b h=%b td=%h cyc=%0d inst=%0d want cyc %0d inst 1",
               trace_valid, halted, trace_data, cycle_count,
               inst_count, exp_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_store();
    test_load();
    test_overflow_push_pop();
    test_halt();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Synthesizable commit-stage observer sitting directly downstream of the processor's MEM/WB commit point, consuming the same retire signals the simulation bench traces (PC, instruction, register write, memory read/write, halt, cache request/hit strobes). It keeps on-chip performance counters and buffers one commit record per active cycle in a small FIFO drained over a valid/ready port. On halt it freezes and signals `done` once the buffer has drained, giving hardware runs the same trace and statistics that simulation provides.

## Interface
- `FIFO_DEPTH`, 8: trace record entries; power of two, ≥2.
- `CNT_W`, 32: width of every performance counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; low means reset.
- `pc`  in  16  PC of the committing instruction.
- `inst`  in  16  instruction word of the committing instruction.
- `reg_write`  in  1  register file written this cycle.
- `write_reg`  in  3  destination register.
- `write_data`  in  16  register write data.
- `mem_read`  in  1  data memory read committed (already stall-qualified).
- `mem_write`  in  1  data memory write committed (already stall-qualified).
- `mem_addr`  in  16  data memory address.
- `mem_data_in`  in  16  store data.
- `mem_data_out`  in  16  load data.
- `halt`  in  1  halt has reached MEM/WB.
- `icache_req`, `icache_hit`, `dcache_req`, `dcache_hit`  in  1 each  cache strobes.
- `trace_valid`  out  1  FIFO head record is valid.
- `trace_ready`  in  1  consumer accepts the head record.
- `trace_data`  out  55  head record: {halt, reg_write, mem_read, mem_write, write_reg[2:0], write_data[15:0], mem_addr[15:0], mem_value[15:0]}, MSB first.
- `cycle_count`, `inst_count`, `icache_req_count`, `icache_hit_count`, `dcache_req_count`, `dcache_hit_count`  out  CNT_W each  counters.
- `drop_count`  out  CNT_W  records lost to a full FIFO.
- `overflow`  out  1  sticky; set on the first dropped record.
- `halted`  out  1  high in HALTED and DONE.
- `done`  out  1  high in DONE.

## Operation
- States: RUN (reset state), HALTED, DONE. RUN→HALTED on the cycle sampling `halt=1`. HALTED→DONE when the FIFO is empty. DONE is left only by reset.
- Commit event (RUN only) = `halt | reg_write | mem_read | mem_write`. It pushes one record; `mem_value` = `mem_write ? mem_data_in : mem_data_out`.
- In RUN, each cycle: `cycle_count`+1. `inst_count`+1 if `halt|reg_write|mem_write`. Each cache counter +1 on its strobe.
- The halt cycle itself is counted and recorded. In HALTED/DONE, every counter and push is frozen; inputs are ignored.
- All counters saturate at all-ones and never wrap.
- FIFO full with no pop in the same cycle: the record, including a halt record, is dropped. `drop_count`+1 (saturating), `overflow`←1.
- Full with push and pop in the same cycle: the push is accepted and occupancy is unchanged.
- Empty with push: no bypass. `trace_valid` rises the next cycle.
- Pop occurs when `trace_valid & trace_ready`. `trace_data` holds stable while `trace_valid & ~trace_ready`.
- `pc` and `inst` are accepted and reserved for later record widening. They do not affect behaviour now.

## Timing
- Reset values: every counter 0, `drop_count` 0, `overflow` 0, `trace_valid` 0, `trace_data` 0, `halted` 0, `done` 0. State is RUN and the FIFO is empty.
- Reset asserted mid-operation clears everything immediately, whatever the FIFO contents or state.
- Counter latency: 1 cycle. Values reflect commits sampled up to and including the previous edge.
- Record latency: a commit sampled at edge N is at the FIFO head no earlier than edge N+1.
- `halted` rises at edge N+1 after halt is sampled at edge N.
- `done` rises on the first edge at which the FIFO is empty while in HALTED.
- `trace_valid`/`trace_data` come from registers. `trace_ready` has no combinational path to any output.

## Structure
- Package `commit_mon_pkg` holds:
  - the state enum {RUN, HALTED, DONE};
  - the packed `trace_rec_t` typedef (55 bits);
  - bit-position constants for the four flag bits.
- Sub-module `trace_fifo`: a parameterised synchronous FIFO (depth, width) with full/empty, simultaneous push/pop and a registered head. The top level holds the FSM, counters and record packing.

## Test plan
- Reset, then 10 idle cycles: `cycle_count`=10, all other counters 0, `trace_valid`=0.
- ADD writing r3=0x1234, then STORE addr 0x0040 data 0xBEEF, with `trace_ready`=1:
  - two records in order, flags 0100 then 0001;
  - `inst_count`=2.
- LOAD (`mem_read`, `reg_write`, r2, `mem_data_out`=0x5A5A): a single record with flags 0110, mem_value 0x5A5A, `inst_count`+1.
- `trace_ready`=0, then 10 commits with depth 8:
  - 8 records retained, `drop_count`=2, `overflow`=1;
  - raising `trace_ready` drains 8 records in order.
- Full FIFO with push and pop in the same cycle: occupancy stays 8, no drop.
- Halt with 3 buffered records:
  - `halted`=1 next cycle and counters frozen despite toggling strobes;
  - `done` rises after the 4th pop (the halt record, flags 1000).
  - A mid-drain `rst` pulse clears the FIFO and returns to RUN.
